basic_shit_cpu_jtag_debug_host: RTL
===================================

BASIC_SHIT_CPU_JTAG_DEBUG_HOST -- requirements
Module: basic_shit_cpu_jtag_debug_host

Interface
REQ-001 SHALL provide parameter TCK_HALF, default 2, clk cycles per vji_tck half-period (minimum 1).
REQ-002 SHALL provide parameter SR_WIDTH, default 38, data-register shift length in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-007 SHALL have port cmd_ir  input  2  virtual IR value for the command.
REQ-008 SHALL have port cmd_data  input  SR_WIDTH  data shifted out on vji_tdi.
REQ-009 SHALL have port rsp_valid  output  1  captured data available.
REQ-010 SHALL have port rsp_ready  input  1  consumer takes response.
REQ-011 SHALL have port rsp_data  output  SR_WIDTH  data captured from vji_tdo.
REQ-012 SHALL have ports vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  output  1 each, and vji_ir_in  output  2: virtual JTAG stimulus to the debug-module TAP side.
REQ-013 SHALL have port vji_tdo  input  1  serial data from the TAP side.

Function
REQ-014 SHALL implement states IDLE, UIR, CDR, SHIFT, UDR, RTI, RESP; transitions IDLE->UIR->CDR->SHIFT->UDR->RTI->RESP->IDLE only.
REQ-015 SHALL assert cmd_ready only in IDLE; accept on cmd_valid&cmd_ready, latching cmd_ir and cmd_data, entering UIR next cycle.
REQ-016 SHALL hold vji_tck low in IDLE and RESP; in all other states toggle it every TCK_HALF clk cycles, starting low at state entry.
REQ-017 SHALL keep UIR, CDR, UDR and RTI each exactly one tck period (2*TCK_HALF cycles); SHIFT exactly SR_WIDTH tck periods.
REQ-018 SHALL drive vji_ir_in with latched cmd_ir from UIR entry until the next accept; 2'b00 in reset.
REQ-019 SHALL assert vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti high exactly while in UIR, CDR, SHIFT, UDR, RTI respectively; one-hot, never overlapping.
REQ-020 SHALL drive vji_tdi = latched data bit i during SHIFT tck period i (LSB first), changing only while vji_tck low; 0 outside SHIFT.
REQ-021 SHALL sample vji_tdo on each low->high vji_tck transition in SHIFT, so rsp_data[i] = sample from period i.
REQ-022 SHALL assert rsp_valid on entry to RESP, holding rsp_data stable until rsp_valid&rsp_ready; then return to IDLE next cycle.
REQ-023 SHALL give accept-to-rsp_valid latency of (SR_WIDTH+4)*2*TCK_HALF cycles (168 at defaults).
REQ-024 SHALL ignore cmd_valid outside IDLE; with rsp_ready already high, RESP lasts exactly one cycle and cmd_ready rises the following cycle.
REQ-025 SHALL keep a tck half-period counter of ceil(log2(TCK_HALF))+1 bits and a bit counter of ceil(log2(SR_WIDTH))+1 bits, both cleared at every state entry.

Reset
REQ-026 SHALL on reset_n low, immediately and regardless of state: state IDLE, cmd_ready 1, rsp_valid 0, rsp_data 0, all vji_* outputs 0, counters 0.
REQ-027 SHALL discard an in-flight command on mid-operation reset; no response is produced for it.
REQ-028 SHALL accept a new command on the first clk edge after reset_n deasserts.

Verification
REQ-029 Defaults, cmd_ir=2'b01, cmd_data=38'h2A_5A5A_5A5A, vji_tdo looped to vji_tdi -> rsp_data=38'h2A_5A5A_5A5A, rsp_valid at cycle 168 after accept.
REQ-030 vji_tdo tied 1, cmd_data=0 -> rsp_data all ones; vji_tdi 0 throughout; vji_ir_in stable at command value.
REQ-031 rsp_ready held low 10 cycles after rsp_valid -> rsp_data stable, cmd_ready low, second cmd_valid ignored until handshake completes.
REQ-032 reset_n pulsed low during SHIFT bit 17 -> all outputs 0 same cycle, cmd_ready 1, no rsp_valid afterwards; next command completes normally.
REQ-033 TCK_HALF=1, back-to-back cmd_valid with rsp_ready high -> vji_tck period 2 clks, latency 84, second accept exactly 2 cycles after first rsp_valid.
REQ-034 Each state: strobe one-hot check -> exactly one of vji_uir/cdr/sdr/udr/rti high, pulse widths 4/4/152/4/4 cycles at defaults.

Source files
------------

// File: rtl/basic_shit_cpu_jtag_debug_host.sv
// basic_shit_cpu_jtag_debug_host: drives one virtual-JTAG IR/DR scan per command and returns the captured data
// Ports:
//   clk, reset_n                 clock and asynchronous active-low reset
//   cmd_valid/cmd_ready          command handshake carrying cmd_ir and cmd_data
//   rsp_valid/rsp_ready          response handshake carrying rsp_data
//   vji_tck, vji_tdi, vji_ir_in  virtual TAP clock, serial data and IR value
//   vji_uir..vji_rti             one-hot phase strobes (UIR, CDR, SHIFT, UDR, RTI)
//   vji_tdo                      serial data returned by the TAP side
module basic_shit_cpu_jtag_debug_host #(
  parameter int TCK_HALF = 2,
  parameter int SR_WIDTH = 38
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_ir,
  input  logic [SR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [SR_WIDTH-1:0] rsp_data,
  output logic                vji_tck,
  output logic                vji_tdi,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti,
  output logic [1:0]          vji_ir_in,
  input  logic                vji_tdo
);
  localparam int CW = $clog2(TCK_HALF) + 1;
  localparam int BW = $clog2(SR_WIDTH) + 1;
  localparam logic [CW-1:0] CMAX = CW'(TCK_HALF - 1);
  localparam logic [BW-1:0] BMAX = BW'(SR_WIDTH - 1);
  typedef enum logic [2:0] {IDLE, UIR, CDR, SHIFT, UDR, RTI, RESP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic tck_q, tck_d;
  logic [1:0] ir_q, ir_d;
  logic [SR_WIDTH-1:0] sr_q, sr_d, rsp_q, rsp_d;
  logic half_end, rise, per_end;
  always_comb begin
    half_end = cnt_q == CMAX;
    rise = half_end && !tck_q;
    per_end = half_end && tck_q;
    state_d = state_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    tck_d = tck_q;
    ir_d = ir_q;
    sr_d = sr_q;
    rsp_d = rsp_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d = UIR;
        ir_d = cmd_ir;
        sr_d = cmd_data;
      end
      UIR: state_d = per_end ? CDR : UIR;
      CDR: state_d = per_end ? SHIFT : CDR;
      SHIFT: begin
        // tdo captured on tck rising; tdi advances on tck falling, so it only moves while tck is low
        if (rise) rsp_d = {vji_tdo, rsp_q[SR_WIDTH-1:1]};
        if (per_end) begin
          sr_d = sr_q >> 1;
          bit_d = bit_q + 1'b1;
          if (bit_q == BMAX) state_d = UDR;
        end
      end
      UDR: state_d = per_end ? RTI : UDR;
      RTI: state_d = per_end ? RESP : RTI;
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && state_q != RESP) begin
      cnt_d = half_end ? '0 : cnt_q + 1'b1;
      tck_d = half_end ? !tck_q : tck_q;
    end
    // every state starts with tck low and fresh counters
    if (state_d != state_q) begin
      cnt_d = '0;
      bit_d = '0;
      tck_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      tck_q <= 1'b0;
      ir_q <= '0;
      sr_q <= '0;
      rsp_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      tck_q <= tck_d;
      ir_q <= ir_d;
      sr_q <= sr_d;
      rsp_q <= rsp_d;
    end
  end
  assign cmd_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_data = rsp_q;
  assign vji_tck = tck_q;
  assign vji_tdi = state_q == SHIFT && sr_q[0];
  assign vji_uir = state_q == UIR;
  assign vji_cdr = state_q == CDR;
  assign vji_sdr = state_q == SHIFT;
  assign vji_udr = state_q == UDR;
  assign vji_rti = state_q == RTI;
  assign vji_ir_in = ir_q;
endmodule
